// File: rtl/bvudiv_sge_seq_checker.sv
// Restoring-division witness checker: q = x udiv s, r = x urem s, sat = (q >=signed t).
// Optional macro BVUDIV_EARLY_EXIT_EN: s==0 or x<s resolves at accept without the DIV phase.

module bvudiv_sge_seq_checker #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_s,
  input  logic [W-1:0] in_t,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_q,
  output logic [W-1:0] out_r,
  output logic         out_sat
);

  // state | meaning
  // IDLE  | waiting for an operand set, in_ready high
  // DIV   | one quotient bit per edge, MSB first, W edges total
  // DONE  | result registers valid, held until out_ready
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  localparam int CW = $clog2(W);

  state_t        state;
  logic [W-1:0]  x_r, s_r, t_r;
  logic [W-1:0]  rem;
  logic [W-1:0]  q_w;
  logic [CW-1:0] cnt;

  logic [W:0]    rem_sh;
  logic          step_ge;
  logic [W-1:0]  rem_nx;
  logic [W-1:0]  q_nx;

  assign in_ready = (state == IDLE);

  // The shifted remainder needs one extra bit before the trial subtract.
  always_comb begin
    rem_sh  = {rem, x_r[cnt]};
    step_ge = (rem_sh >= {1'b0, s_r});
    rem_nx  = step_ge ? W'(rem_sh - {1'b0, s_r}) : rem_sh[W-1:0];
    q_nx    = q_w;
    q_nx[cnt] = step_ge;
  end

`ifdef BVUDIV_EARLY_EXIT_EN
  logic         ee_hit;
  logic [W-1:0] ee_q;
  assign ee_hit = (in_s == '0) || (in_x < in_s);
  assign ee_q   = (in_s == '0) ? '1 : '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_sat   <= 1'b0;
      cnt       <= '0;
      rem       <= '0;
      q_w       <= '0;
      x_r       <= '0;
      s_r       <= '0;
      t_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_r <= in_x;
            s_r <= in_s;
            t_r <= in_t;
            rem <= '0;
            q_w <= '0;
            cnt <= CW'(W - 1);
`ifdef BVUDIV_EARLY_EXIT_EN
            if (ee_hit) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_q     <= ee_q;
              out_r     <= in_x;
              out_sat   <= ($signed(ee_q) >= $signed(in_t));
            end else begin
              state <= DIV;
            end
`else
            state <= DIV;
`endif
          end
        end
        DIV: begin
          rem <= rem_nx;
          q_w <= q_nx;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_q     <= q_nx;
            out_r     <= rem_nx;
            out_sat   <= ($signed(q_nx) >= $signed(t_r));
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bvudiv_sge_seq_checker.sv
// Bench for bvudiv_sge_seq_checker: directed literal cases, random traffic, exhaustive sweep,
// all watched by a per-cycle reference model of bvudiv/bvurem/bvsge and the handshake.

module tb_bvudiv_sge_seq_checker;
  localparam int W = 4;
`ifdef BVUDIV_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] in_x = '0, in_s = '0, in_t = '0;
  logic         in_ready, out_valid, out_sat;
  logic [W-1:0] out_q, out_r;

  int checks = 0;
  int failures = 0;

  bvudiv_sge_seq_checker #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_s(in_s), .in_t(in_t),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // SMT-LIB semantics: x udiv 0 = all ones, x urem 0 = x.
  task automatic ref_eval(input logic [W-1:0] x, input logic [W-1:0] s, input logic [W-1:0] t,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic sat);
    if (s == 0) begin
      q = '1;
      r = x;
    end else begin
      q = x / s;
      r = x % s;
    end
    sat = ($signed(q) >= $signed(t));
  endtask

  // Model: phase 0 idle, 1 dividing (m_left edges to go), 2 result held.
  bit           m_known = 1'b0;
  bit           m_zero_outs = 1'b0;
  int           m_phase = 0;
  int           m_left = 0;
  logic [W-1:0] m_q = '0, m_r = '0;
  logic         m_sat = 1'b0;

  always @(negedge clk) begin
    if (m_known) begin
      chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
      chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
      if (m_phase == 2 || m_zero_outs) begin
        chk("out_q", 32'(out_q), 32'(m_q));
        chk("out_r", 32'(out_r), 32'(m_r));
        chk("out_sat", 32'(out_sat), 32'(m_sat));
      end
    end
    if (!rst_n) begin
      m_known = 1'b1;
      m_phase = 0;
      m_left = 0;
      m_q = '0;
      m_r = '0;
      m_sat = 1'b0;
      m_zero_outs = 1'b1;
    end else if (m_known) begin
      case (m_phase)
        0: if (in_valid) begin
          ref_eval(in_x, in_s, in_t, m_q, m_r, m_sat);
          m_zero_outs = 1'b0;
          if (EE && (in_s == 0 || in_x < in_s)) m_phase = 2;
          else begin
            m_phase = 1;
            m_left = W;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // Offers one operand set from IDLE; latency counts edges after the accept edge.
  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] s,
                        input logic [W-1:0] t, input int eq, input int er, input int esat,
                        input int elat);
    int edges;
    @(posedge clk); #1;
    in_x = x; in_s = s; in_t = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(edges);
    chk({tag, "_latency"}, 32'(edges), 32'(elat));
    chk({tag, "_q"}, 32'(out_q), 32'(eq));
    chk({tag, "_r"}, 32'(out_r), 32'(er));
    chk({tag, "_sat"}, 32'(out_sat), 32'(esat));
  endtask

  initial begin
    int edges;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_q", 32'(out_q), 32'd0);
    chk("reset_out_sat", 32'(out_sat), 32'd0);

    run_op("t1", 4'd13, 4'd3, 4'd2, 4, 1, 1, W);
    run_op("t2", 4'd9, 4'd0, 4'd0, 15, 9, 0, EE ? 0 : W);
    run_op("t3", 4'd0, 4'd7, 4'b1000, 0, 0, 1, EE ? 0 : W);

    // backpressure: hold DONE five cycles while new operands are offered
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_x = 4'd6; in_s = 4'd2; in_t = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(edges);
    in_valid = 1'b1; in_x = 4'd1; in_s = 4'd1; in_t = 4'd7;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_q", 32'(out_q), 32'd3);
      chk("bp_r", 32'(out_r), 32'd0);
      chk("bp_sat", 32'(out_sat), 32'd1);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_exit_in_ready", 32'(in_ready), 32'd1);
    chk("bp_exit_valid", 32'(out_valid), 32'd0);

    // reset landing on the second DIV step
    in_x = 4'd10; in_s = 4'd3; in_t = 4'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_q", 32'(out_q), 32'd0);
    chk("abort_r", 32'(out_r), 32'd0);
    chk("abort_sat", 32'(out_sat), 32'd0);
    run_op("t5", 4'd15, 4'd15, 4'd1, 1, 0, 1, W);

    // random traffic, model checks every cycle
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_x      = W'($urandom);
      in_s      = W'($urandom);
      in_t      = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (W + 3) @(posedge clk);
    #1;

    // exhaustive back-to-back sweep
    for (int x = 0; x < 16; x++)
      for (int s = 0; s < 16; s++)
        for (int t = 0; t < 16; t++) begin
          int n;
          in_x = W'(x); in_s = W'(s); in_t = W'(t); in_valid = 1'b1;
          n = 0;
          @(negedge clk);
          while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
          end
          if (n >= 50) chk("sweep_accept_timeout", 32'(in_ready), 32'd1);
          @(posedge clk); #1;
        end
    in_valid = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
